mux8_rr_arbiter: RTL

- Round-robin arbiter that shares one 8:1 bit-select datapath among 8 requesters.
- Registers a one-hot grant and drives the s2/s1/s0 select lines of an internal mux_8x1.
- Outputs the granted requester's data bit, gated by grant valid.
- Sits between 8 serial sources and a single shared serial sink; enforces fairness and a bounded hold time.

---
 rtl/mux8_arb_pkg.sv | 15 +
 rtl/mux_8x1.sv | 28 ++
 rtl/mux8_rr_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/mux8_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (oh[i]) idx = idx | IDX_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/mux_8x1.sv
// Plain 8:1 bit multiplexer; {s2,s1,s0} selects input i0..i7.
module mux_8x1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic i4,
  input  logic i5,
  input  logic i6,
  input  logic i7,
  input  logic s2,
  input  logic s1,
  input  logic s0,
  output logic y
);
  always_comb begin
    case ({s2, s1, s0})
      3'd0:    y = i0;
      3'd1:    y = i1;
      3'd2:    y = i2;
      3'd3:    y = i3;
      3'd4:    y = i4;
      3'd5:    y = i5;
      3'd6:    y = i6;
      default: y = i7;
    endcase
  end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter with bounded hold driving a shared mux_8x1 datapath.
// Define MUX8_ARB_PARK_EN to keep the last select while idle instead of forcing 0.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic               s2,
  output logic               s1,
  output logic               s0,
  output logic               dout
);
  arb_state_t         state, nxt_state;
  logic [IDX_W-1:0]   sel, nxt_sel, ptr, nxt_ptr;
  logic [CNT_W-1:0]   hold_cnt, nxt_cnt;
  logic [NUM_REQ-1:0] nxt_gnt;
  logic [IDX_W-1:0]   cur_idx, win_idx, scan;
  logic               found, release_g, mux_y;

  // ptr already sits at g+1 while granted, so one scan serves both idle and release.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    scan    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = ptr + IDX_W'(i);
      if (!found && req[scan]) begin
        found   = 1'b1;
        win_idx = scan;
      end
    end
  end

  assign cur_idx   = onehot_to_idx(gnt);
  assign release_g = !req[cur_idx] || (hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    nxt_state = state;
    nxt_gnt   = gnt;
    nxt_sel   = sel;
    nxt_ptr   = ptr;
    nxt_cnt   = hold_cnt;
    if (state == GRANT && !release_g) begin
      nxt_cnt = hold_cnt + CNT_W'(1);
    end else if (found) begin
      nxt_state = GRANT;
      nxt_gnt   = NUM_REQ'(1) << win_idx;
      nxt_sel   = win_idx;
      nxt_ptr   = win_idx + IDX_W'(1);
      nxt_cnt   = '0;
    end else begin
      nxt_state = IDLE;
      nxt_gnt   = '0;
      nxt_cnt   = '0;
`ifdef MUX8_ARB_PARK_EN
      nxt_sel   = sel;
`else
      nxt_sel   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      sel       <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= nxt_state;
      gnt       <= nxt_gnt;
      gnt_valid <= (nxt_state == GRANT);
      sel       <= nxt_sel;
      ptr       <= nxt_ptr;
      hold_cnt  <= nxt_cnt;
    end
  end

  assign {s2, s1, s0} = sel;

  mux_8x1 u_mux (
    .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
    .i4(din[4]), .i5(din[5]), .i6(din[6]), .i7(din[7]),
    .s2(s2), .s1(s1), .s0(s0),
    .y (mux_y)
  );

  assign dout = mux_y & gnt_valid;
endmodule
